// File: rtl/neuron_pkg.sv
// Shared widths and slot state encoding for the sigmoid LUT arbiter.
package neuron_pkg;

    localparam int LUT_ADDR_W = 10;
    localparam int LUT_DATA_W = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INFLIGHT = 2'd1,
        DONE     = 2'd2
    } slot_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector.
// The pointer names the highest-priority index and moves past each winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_cand;

    // Scan upward from the pointer with wrap; first requester found wins
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
        if (o_any) o_gnt[o_idx] = 1'b1;
    end

    // Next pointer is one past the winner; unchanged when nobody wins
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (o_any)
            w_ptr_nxt = (o_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_idx + IDX_W'(1);
    end

    // Pointer register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_ptr <= '0;
        else        r_ptr <= w_ptr_nxt;
    end

endmodule

// File: rtl/sigmoid_lut_arbiter.sv
// Shares one sigmoid LUT between NUM_REQ neuron requesters.
// Each requester owns a slot (IDLE/INFLIGHT/DONE); a round-robin arbiter
// picks one IDLE requester per cycle, its index rides a tag pipeline beside
// the registered LUT address, and the returning data lands in its slot.
// Optional build macro SIGMOID_ARB_STATS_EN adds grant/conflict counters.
module sigmoid_lut_arbiter
    import neuron_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LUT_LAT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    io_req_valid,
    input  logic [NUM_REQ*10-1:0] io_req_addr,
    output logic [NUM_REQ-1:0]    io_req_ready,
    output logic [NUM_REQ-1:0]    io_resp_valid,
    output logic [NUM_REQ*10-1:0] io_resp_data,
    input  logic [NUM_REQ-1:0]    io_resp_ready,
    output logic [9:0]            io_lut_addr,
    input  logic [9:0]            io_lut_data
`ifdef SIGMOID_ARB_STATS_EN
    ,
    output logic [31:0]           io_grant_cnt,
    output logic [31:0]           io_conflict_cnt
`endif
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    slot_state_t r_state     [NUM_REQ];
    slot_state_t w_state_nxt [NUM_REQ];

    logic [NUM_REQ-1:0]                 w_idle;
    logic [NUM_REQ-1:0]                 w_elig;
    logic [NUM_REQ-1:0]                 w_gnt;
    logic [TAG_W-1:0]                   w_idx;
    logic                               w_any;
    logic [NUM_REQ-1:0][LUT_ADDR_W-1:0] w_req_addr;
    logic [NUM_REQ-1:0][LUT_DATA_W-1:0] r_data;
    logic [LUT_ADDR_W-1:0]              r_lut_addr;
    logic [LUT_LAT:0]                   r_vld_pipe;
    logic [LUT_LAT:0][TAG_W-1:0]        r_tag_pipe;
    logic                               w_cap;
    logic [TAG_W-1:0]                   w_cap_tag;

    assign w_req_addr   = io_req_addr;
    assign io_resp_data = r_data;
    assign io_lut_addr  = r_lut_addr;
    assign io_req_ready = w_gnt;
    assign w_cap        = r_vld_pipe[LUT_LAT];
    assign w_cap_tag    = r_tag_pipe[LUT_LAT];

    // Slot status decode; kept apart from next-state to avoid a false comb loop
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idle[i]        = (r_state[i] == IDLE);
            io_resp_valid[i] = (r_state[i] == DONE);
        end
    end

    // Only IDLE slots compete, and nothing is granted while reset is held
    assign w_elig = io_req_valid & w_idle & {NUM_REQ{reset}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (TAG_W)
    ) u_rr (
        .clock (clock),
        .reset (reset),
        .i_req (w_elig),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Slot next-state: accept, capture by tag, release on response handshake
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                IDLE:     if (w_gnt[i]) w_state_nxt[i] = INFLIGHT;
                INFLIGHT: if (w_cap && (w_cap_tag == TAG_W'(i))) w_state_nxt[i] = DONE;
                DONE:     if (io_resp_ready[i]) w_state_nxt[i] = IDLE;
                default:  w_state_nxt[i] = IDLE;
            endcase
        end
    end

    // Slot state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) r_state[i] <= IDLE;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    // LUT address register and the tag pipeline that tracks the read latency
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lut_addr <= '0;
            r_vld_pipe <= '0;
            r_tag_pipe <= '0;
        end else begin
            if (w_any) r_lut_addr <= w_req_addr[w_idx];
            r_vld_pipe[0] <= w_any;
            r_tag_pipe[0] <= w_idx;
            for (int k = 1; k <= LUT_LAT; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_tag_pipe[k] <= r_tag_pipe[k-1];
            end
        end
    end

    // Result buffers: LUT data lands in the slot named by the tag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     r_data <= '0;
        else if (w_cap) r_data[w_cap_tag] <= io_lut_data;
    end

`ifdef SIGMOID_ARB_STATS_EN
    logic [31:0] r_grant_cnt;
    logic [31:0] r_conflict_cnt;

    assign io_grant_cnt    = r_grant_cnt;
    assign io_conflict_cnt = r_conflict_cnt;

    // Free-running wrap-around counters of grants and contended cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_grant_cnt    <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_any)                r_grant_cnt    <= r_grant_cnt + 32'd1;
            if ($countones(w_elig) > 1) r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// Directed bench for sigmoid_lut_arbiter with a one-cycle LUT model.
// Build with SIGMOID_ARB_STATS_EN defined to also check the counters.
module tb_sigmoid_lut_arbiter;

    localparam int N = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*10-1:0] req_addr = '0;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  resp_valid;
    logic [N*10-1:0] resp_data;
    logic [N-1:0]  resp_ready = '0;
    logic [9:0]    lut_addr;
    logic [9:0]    lut_data = '0;
`ifdef SIGMOID_ARB_STATS_EN
    logic [31:0]   grant_cnt;
    logic [31:0]   conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sigmoid_lut_arbiter #(.NUM_REQ(N), .LUT_LAT(1)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_req_valid  (req_valid),
        .io_req_addr   (req_addr),
        .io_req_ready  (req_ready),
        .io_resp_valid (resp_valid),
        .io_resp_data  (resp_data),
        .io_resp_ready (resp_ready),
        .io_lut_addr   (lut_addr),
        .io_lut_data   (lut_data)
`ifdef SIGMOID_ARB_STATS_EN
        ,
        .io_grant_cnt    (grant_cnt),
        .io_conflict_cnt (conflict_cnt)
`endif
    );

    // LUT contents: an arbitrary but distinct mapping
    function automatic logic [9:0] lut_f(input logic [9:0] a);
        logic [9:0] r;
        r = a * 10'd3 + 10'd7;
        return r;
    endfunction

    // One-cycle LUT read
    always @(posedge clock) lut_data <= lut_f(lut_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [9:0] rdata(input int i);
        return resp_data[i*10 +: 10];
    endfunction

    logic [9:0] a4 [N];
    logic [N-1:0] expv;
    logic [N-1:0] exp_rdy [5];
    int others;

    initial begin
        // ---------------- reset state, with a request already pending
        req_valid = 4'b0001;
        req_addr[9:0] = 10'h200;
        repeat (3) step();
        check("rst_ready",     32'(req_ready),  32'd0);
        check("rst_resp_vld",  32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data[31:0]), 32'd0);
        check("rst_lut_addr",  32'(lut_addr),   32'd0);

        // ---------------- single request, addr 0x200
        reset = 1'b1;
        #1;
        check("single_ready", 32'(req_ready), 32'(4'b0001));
        step();                                   // accept edge T
        check("single_lut_addr", 32'(lut_addr), 32'h200);
        check("single_ready_busy", 32'(req_ready), 32'd0);
        req_valid = '0;
        step();                                   // T+1
        check("single_vld_t1", 32'(resp_valid), 32'd0);
        check("lut_addr_hold", 32'(lut_addr), 32'h200);
        step();                                   // T+2
        check("single_vld_t2", 32'(resp_valid), 32'(4'b0001));
        check("single_data",   32'(rdata(0)), 32'(lut_f(10'h200)));
        step();                                   // not consumed yet
        check("single_vld_hold",  32'(resp_valid), 32'(4'b0001));
        check("single_data_hold", 32'(rdata(0)), 32'(lut_f(10'h200)));
        resp_ready = 4'b0001;
        step();
        check("single_consumed", 32'(resp_valid), 32'd0);
        resp_ready = '0;

        // ---------------- all four valid from reset release
        reset = 1'b0;
        step();
        a4[0] = 10'h011; a4[1] = 10'h022; a4[2] = 10'h033; a4[3] = 10'h044;
        for (int i = 0; i < N; i++) req_addr[i*10 +: 10] = a4[i];
        req_valid = 4'b1111;
        step();
        reset = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("all_ready_%0d", k), 32'(req_ready), 32'(4'b0001 << k));
            step();
            check($sformatf("all_lut_addr_%0d", k), 32'(lut_addr), 32'(a4[k]));
            req_valid[k] = 1'b0;
            expv = '0;
            for (int j = 0; j < N; j++) if (j + 2 <= k) expv[j] = 1'b1;
            check($sformatf("all_resp_vld_%0d", k), 32'(resp_valid), 32'(expv));
        end
        step();
        check("all_resp_vld_4", 32'(resp_valid), 32'(4'b0111));
        step();
        check("all_resp_vld_5", 32'(resp_valid), 32'(4'b1111));
        for (int i = 0; i < N; i++)
            check($sformatf("all_data_%0d", i), 32'(rdata(i)), 32'(lut_f(a4[i])));
`ifdef SIGMOID_ARB_STATS_EN
        check("stats_grant",    grant_cnt,    32'd4);
        check("stats_conflict", conflict_cnt, 32'd3);
`endif

        // ---------------- requester 2 stalls its response for 10 cycles
        for (int i = 0; i < N; i++) req_addr[i*10 +: 10] = 10'h101 + 10'(i);
        req_valid  = 4'b1111;
        resp_ready = 4'b1011;
        exp_rdy[0] = 4'b0000; exp_rdy[1] = 4'b0001; exp_rdy[2] = 4'b0010;
        exp_rdy[3] = 4'b1000; exp_rdy[4] = 4'b0000;
        others = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c < 5) check($sformatf("stall_ready_%0d", c), 32'(req_ready), 32'(exp_rdy[c]));
            check($sformatf("stall_vld2_%0d", c),  32'(resp_valid[2]), 32'd1);
            check($sformatf("stall_data2_%0d", c), 32'(rdata(2)), 32'(lut_f(10'h033)));
            check($sformatf("stall_rdy2_%0d", c),  32'(req_ready[2]), 32'd0);
            others += int'(req_ready[0]) + int'(req_ready[1]) + int'(req_ready[3]);
            step();
        end
        check("stall_others_served", 32'(others >= 3), 32'd1);
        resp_ready[2] = 1'b1;                     // handshake with valid still high
        #1;
        check("same_cycle_ready2", 32'(req_ready[2]), 32'd0);
        step();
        check("same_cycle_consumed", 32'(resp_valid[2]), 32'd0);
        req_valid  = '0;
        resp_ready = 4'b1111;
        repeat (6) step();
        check("drain_vld", 32'(resp_valid), 32'd0);

        // ---------------- pointer at 3, requesters 1 and 3
        reset = 1'b0;
        step();
        reset = 1'b1;
        req_addr[29:20] = 10'h0F0;
        req_valid = 4'b0100;
        #1;
        check("ptr_setup_ready", 32'(req_ready), 32'(4'b0100));
        step();
        req_valid = '0;
        repeat (4) step();
        req_addr[19:10] = 10'h111;
        req_addr[39:30] = 10'h333;
        req_valid = 4'b1010;
        #1;
        check("ptr3_first", 32'(req_ready), 32'(4'b1000));
        step();
        check("ptr3_first_addr", 32'(lut_addr), 32'h333);
        check("ptr3_second", 32'(req_ready), 32'(4'b0010));
        step();
        check("ptr3_second_addr", 32'(lut_addr), 32'h111);
        req_valid = '0;
        repeat (5) step();

        // ---------------- reset one cycle after an accept
        req_addr[9:0] = 10'h0AB;
        req_valid = 4'b0001;
        #1;
        check("rst_mid_ready", 32'(req_ready), 32'(4'b0001));
        step();
        req_valid = '0;
        step();
        reset = 1'b0;
        #1;
        check("rst_mid_lut_addr", 32'(lut_addr), 32'd0);
        step();
        step();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("rst_mid_no_resp_%0d", c), 32'(resp_valid), 32'd0);
        end
        req_addr[19:10] = 10'h3C5;
        req_valid = 4'b0010;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'(4'b0010));
        resp_ready = '0;
        step();
        req_valid = '0;
        step();
        step();
        check("post_rst_vld",  32'(resp_valid), 32'(4'b0010));
        check("post_rst_data", 32'(rdata(1)), 32'(lut_f(10'h3C5)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sigmoid_lut_arbiter.md
SIGMOID_LUT_ARBITER -- requirements
Module: sigmoid_lut_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of neuron requesters sharing one sigmoid LUT.
REQ-002 SHALL have parameter LUT_LAT, default 1: LUT read latency in cycles, from address register to data valid.
REQ-003 SHALL have port clock  in  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port io_req_valid  in  NUM_REQ  per-requester lookup request.
REQ-006 SHALL have port io_req_addr  in  NUM_REQ*10  per-requester LUT address; requester i occupies bits [10i+9:10i].
REQ-007 SHALL have port io_req_ready  out  NUM_REQ  request accepted when valid&ready.
REQ-008 SHALL have port io_resp_valid  out  NUM_REQ  per-requester result available.
REQ-009 SHALL have port io_resp_data  out  NUM_REQ*10  per-requester sigmoid result, same packing as io_req_addr.
REQ-010 SHALL have port io_resp_ready  in  NUM_REQ  requester consumes its result.
REQ-011 SHALL have port io_lut_addr  out  10  address to the shared SigmoidLut.
REQ-012 SHALL have port io_lut_data  in  10  SigmoidLut read data.

Function
REQ-013 Each requester SHALL have a slot state machine: IDLE -> INFLIGHT on accept; INFLIGHT -> DONE on LUT data capture; DONE -> IDLE on io_resp_valid&io_resp_ready.
REQ-014 Eligible set = requesters with io_req_valid=1 and slot IDLE; at most one grant per cycle, by round-robin.
REQ-015 Round-robin pointer SHALL move to (granted index+1) mod NUM_REQ after each grant and hold when there is no grant.
REQ-016 io_req_ready[i] SHALL be 1 only when i is the granted index; it is combinational from io_req_valid and slot state.
REQ-017 On accept at edge T, io_lut_addr SHALL be registered with the granted address and hold it from T; io_lut_data SHALL be captured into slot i's buffer at edge T+LUT_LAT+1; io_resp_valid[i] SHALL be 1 from that edge.
REQ-018 A requester index SHALL travel in a LUT_LAT+1 deep tag pipeline beside the address, so one accept per cycle is sustained.
REQ-019 io_resp_data[i] and io_resp_valid[i] SHALL stay stable while DONE and not consumed.
REQ-020 A response handshake and a new request from the same requester in the same cycle: ready SHALL be 0 that cycle, and the new request SHALL be accepted no earlier than the next cycle.
REQ-021 io_lut_addr SHALL hold its last value when there is no grant.

Reset
REQ-022 While reset=0: slots IDLE, pointer 0, tag pipeline invalid, io_req_ready=0, io_resp_valid=0, io_resp_data=0, io_lut_addr=0.
REQ-023 Reset mid-operation SHALL discard in-flight and DONE results; no response SHALL appear after release for pre-reset requests.

Configuration
REQ-024 Macro SIGMOID_ARB_STATS_EN SHALL add outputs io_grant_cnt (32) and io_conflict_cnt (32).
REQ-025 io_grant_cnt SHALL count grants; io_conflict_cnt SHALL count cycles with more than one eligible requester.
REQ-026 Both counters SHALL wrap at 2^32 and reset to 0.
REQ-027 Without SIGMOID_ARB_STATS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package neuron_pkg SHALL hold LUT_ADDR_W=10, LUT_DATA_W=10 and the slot state enum (IDLE, INFLIGHT, DONE).
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (NUM_REQ request vector in, one-hot grant out, pointer inside).

Verification
REQ-030 Single request: req 0 valid, addr 0x200, LUT_LAT=1, accept at T -> io_lut_addr=0x200 from T; resp_valid[0]=1 at T+2 with LUT[0x200].
REQ-031 All four requesters valid from reset release -> grants in order 0,1,2,3, one per cycle; responses arrive in the same order.
REQ-032 Requester 2 holds resp_ready=0 for 10 cycles with valid held -> resp_data[2] stable, ready[2]=0, others keep being served.
REQ-033 Pointer at 3, requesters 1 and 3 valid -> grant 3, then 1.
REQ-034 reset=0 asserted one cycle after an accept -> no resp_valid after release; first new request returns its correct data.
REQ-035 With SIGMOID_ARB_STATS_EN, the REQ-031 stimulus -> io_grant_cnt=4; io_conflict_cnt=3.
